thor2024_rt_scoreboard: RTL
===========================

Name: thor2024_rt_scoreboard

Overview:
Register-file write scoreboard for the Thor2024 issue stage. It takes the decoded target register (Rt) and source registers of the instruction presented for issue. It marks Rt busy when that instruction issues and clears the mark when its writeback arrives. Issue is held off on RAW/WAW hazards, and a quiesce (drain) handshake plus a kill clear serve pipeline flushes.

Parameters:
NWB, 2, number of writeback ports.
NREG, 64, architectural registers; regspec_t width is 6. Register 0 is never busy.
STALLW, 32, width of the saturating stall-cycle counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
iss_valid  input  1  instruction presented for issue.
iss_ready  output  1  scoreboard permits issue this cycle.
iss_Rt  input  6  decoded target register (0 = no target).
iss_Ra  input  6  source A (0 = unused).
iss_Rb  input  6  source B (0 = unused).
iss_Rc  input  6  source C (0 = unused).
wb_valid  input  NWB  per-port writeback strobe.
wb_Rt  input  NWB*6  per-port writeback register, port k at bits [6k+5:6k].
kill  input  1  pipeline flush; discard all pending writes.
quiesce_req  input  1  request to drain all outstanding writes.
quiesce_ack  output  1  one-cycle pulse when drain is complete.
busy_vec  output  NREG  registered busy bits; bit 0 always 0.
busy_count  output  7  popcount of busy_vec.
stall_cnt  output  STALLW  cycles lost to hazards, saturating.
wb_err  output  1  sticky: writeback to a non-busy nonzero register.

Behaviour:
- Reset (rst_n low, async): busy_vec=0, busy_count=0, stall_cnt=0, wb_err=0, quiesce_ack=0, state=RUN.
- eff_busy[r]: busy_vec[r] without the optional feature; see Optional Feature for the bypass form.
- hazard = (Ra!=0 & eff_busy[Ra]) | (Rb!=0 & eff_busy[Rb]) | (Rc!=0 & eff_busy[Rc]) | (Rt!=0 & eff_busy[Rt]).
- iss_ready = (state==RUN) & !hazard & !kill. It is combinational and does not depend on iss_valid.
- Issue fires on iss_valid & iss_ready. If iss_Rt!=0, busy_vec[iss_Rt] <= 1 next edge (one-cycle latency).
- Writeback: for each k with wb_valid[k] & wb_Rt[k]!=0, busy_vec[wb_Rt[k]] <= 0.
  - If that bit was 0 and it is not being set this cycle, wb_err <= 1 (sticky until reset).
  - Multiple ports naming the same register: cleared once, no error.
  - wb_Rt=0 is ignored.
- Same-cycle set and clear of the same register: set wins.
- kill: busy_vec <= 0 next edge; issue and writeback that cycle are discarded. stall_cnt and wb_err are unaffected. If state is DRAIN, go to ACK.
- busy_count is combinational popcount of registered busy_vec (0..63).
- stall_cnt increments when iss_valid & !iss_ready & state==RUN & !kill, saturating at all-ones.
- FSM states RUN, DRAIN, ACK:
  - RUN: quiesce_req goes to DRAIN. Issue is still allowed in that same cycle.
  - DRAIN: iss_ready=0. When busy_count==0 (registered value) go to ACK.
  - ACK: quiesce_ack=1 for exactly one cycle, then RUN. quiesce_req level is ignored in ACK; a new request needs it high again in RUN.
  - quiesce_req while in DRAIN/ACK has no further effect.
- Reset mid-DRAIN returns the FSM to RUN with no ack.

Optional Feature:
Macro THOR_SB_BYPASS_EN.
- Defined: eff_busy[r] = busy_vec[r] & !(any valid wb port naming r this cycle). A writeback releases dependents in the same cycle.
- Undefined: eff_busy = busy_vec. A dependent issues at the earliest one cycle after its writeback.
- Busy tracking, DRAIN exit and all other behaviour are identical in both builds.

Test Plan:
- Reset then issue Rt=5, Ra=0: iss_ready=1, busy_vec[5]=1 next cycle, busy_count=1. Next issue Ra=5 → iss_ready=0, stall_cnt increments each held cycle.
- wb_valid[1]=1, wb_Rt=5 while dependent Ra=5 waits: bypass build issues the same cycle; non-bypass build issues the next cycle with stall_cnt +1 more.
- Issue Rt=0, then Rt=0 again: no busy bits set, no WAW stall. Then wb_Rt=9 with reg 9 not busy → wb_err=1 and stays 1.
- Busy {3,7}, assert quiesce_req: iss_ready=0. wb 3, then wb 7 → ACK the cycle after busy_count reaches 0, quiesce_ack high for exactly 1 cycle, then RUN.
- Busy {3,7,12}, kill=1 with iss_valid Rt=20 and wb_Rt=3 the same cycle: next cycle busy_vec=0, reg 20 not busy, wb_err unchanged.
- Issue Rt=4 and wb_Rt=4 in the same cycle (reg 4 idle): busy_vec[4]=1 (set wins), wb_err=0.

Source files
------------

// File: rtl/thor2024_rt_scoreboard.sv
// rtl/thor2024_rt_scoreboard.sv - Thor2024 issue-stage register write scoreboard
//
// Tracks which architectural registers have a write in flight. A register is
// marked busy when an instruction targeting it issues and is released when
// its writeback arrives. Issue is held off on RAW/WAW hazards. Pipeline
// flushes use a kill clear and a quiesce (drain) handshake.
//
// Optional build macro: THOR_SB_BYPASS_EN
//   defined   - a writeback releases its dependents in the same cycle
//   undefined - dependents issue at the earliest one cycle after writeback
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   iss_valid / iss_ready       issue handshake (iss_ready is combinational)
//   iss_Rt                      target register of the issuing instruction (0 = none)
//   iss_Ra, iss_Rb, iss_Rc      source registers (0 = unused)
//   wb_valid[NWB], wb_Rt        writeback strobes and registers, port k at [6k+5:6k]
//   kill                        discard all pending writes
//   quiesce_req / quiesce_ack   drain request, one-cycle completion pulse
//   busy_vec, busy_count        registered busy bits and their popcount
//   stall_cnt                   saturating count of hazard-stalled cycles
//   wb_err                      sticky: writeback to a non-busy register
module thor2024_rt_scoreboard #(
  parameter int NWB    = 2,
  parameter int NREG   = 64,
  parameter int STALLW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [5:0]          iss_Rt,
  input  logic [5:0]          iss_Ra,
  input  logic [5:0]          iss_Rb,
  input  logic [5:0]          iss_Rc,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*6-1:0]    wb_Rt,
  input  logic                kill,
  input  logic                quiesce_req,
  output logic                quiesce_ack,
  output logic [NREG-1:0]     busy_vec,
  output logic [6:0]          busy_count,
  output logic [STALLW-1:0]   stall_cnt,
  output logic                wb_err
);

  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

  state_t            state, state_nxt;
  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   eff_busy;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   busy_nxt;
  logic              hazard;
  logic              fire;
  logic              wb_bad;
  logic              stall_hit;

  // Registers named by a valid writeback port this cycle; register 0 ignored.
  always_comb begin
    wb_hit = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_valid[k] && (wb_Rt[k*6 +: 6] != 6'd0)) begin
        wb_hit[wb_Rt[k*6 +: 6]] = 1'b1;
      end
    end
  end

`ifdef THOR_SB_BYPASS_EN
  assign eff_busy = busy_vec & ~wb_hit;
`else
  assign eff_busy = busy_vec;
`endif

  assign hazard = ((iss_Ra != 6'd0) && eff_busy[iss_Ra]) ||
                  ((iss_Rb != 6'd0) && eff_busy[iss_Rb]) ||
                  ((iss_Rc != 6'd0) && eff_busy[iss_Rc]) ||
                  ((iss_Rt != 6'd0) && eff_busy[iss_Rt]);

  assign iss_ready = (state == RUN) && !hazard && !kill;
  assign fire      = iss_valid && iss_ready;
  assign stall_hit = iss_valid && !iss_ready && (state == RUN) && !kill;

  always_comb begin
    set_vec = '0;
    if (fire && (iss_Rt != 6'd0)) begin
      set_vec[iss_Rt] = 1'b1;
    end
  end

  // A writeback to an idle register is an error unless the same register is
  // being claimed by an issue this cycle (set wins, so the clear is moot).
  assign wb_bad = (|(wb_hit & ~busy_vec & ~set_vec)) && !kill;

  always_comb begin
    busy_nxt    = kill ? '0 : ((busy_vec & ~wb_hit) | set_vec);
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    busy_count = 7'd0;
    for (int i = 0; i < NREG; i++) begin
      busy_count = busy_count + 7'(busy_vec[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (quiesce_req) state_nxt = DRAIN;
      DRAIN:   if (kill || (busy_count == 7'd0)) state_nxt = ACK;
      ACK:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign quiesce_ack = (state == ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      busy_vec  <= '0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_vec <= busy_nxt;
      if (stall_hit && (stall_cnt != {STALLW{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (wb_bad) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule
